// File: rtl/ripple_count_monitor.sv
// Samples an asynchronous 4-bit ripple counter, filters out ripple glitches, and accepts only settled values.
// For each accepted step it reports the direction, any wrap, any skipped count, and any disagreement with up_down.
module ripple_count_monitor #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] cnt_in,
   input  logic       up_down,
   output logic [3:0] count_sync,
   output logic       step_pulse,
   output logic       dir_up,
   output logic       wrap_pulse,
   output logic       skip_err,
   output logic       dir_err,
   output logic [7:0] step_total
);

   // state | meaning
   // INIT  | no value accepted since reset; the next accepted value only loads count_sync
   // TRACK | accepted values are classified against count_sync
   typedef enum logic {INIT, TRACK} state_t;

   localparam logic [2:0] SETTLE_C = 3'(SETTLE);

   state_t     state, state_n;
   logic [3:0] cnt_s1, cnt_s2;
   logic       ud_s1, ud_s2;
   logic [1:0] primed;
   logic [3:0] cand;
   logic       cand_vld;
   logic [2:0] stable;
   logic       accept;
   logic [3:0] delta;

   logic [3:0] count_n;
   logic       dir_n, step_n, wrap_n, skip_n, derr_n;
   logic [7:0] total_n;

   // The synchronizer contents after reset are not real samples, so the filter
   // waits until both flops hold samples before it loads its first candidate.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cnt_s1   <= '0;
         cnt_s2   <= '0;
         ud_s1    <= 1'b0;
         ud_s2    <= 1'b0;
         primed   <= '0;
         cand     <= '0;
         cand_vld <= 1'b0;
         stable   <= '0;
      end else begin
         cnt_s1 <= cnt_in;
         cnt_s2 <= cnt_s1;
         ud_s1  <= up_down;
         ud_s2  <= ud_s1;
         primed <= {primed[0], 1'b1};
         if (primed[1]) begin
            if (!cand_vld || cnt_s2 != cand) begin
               cand     <= cnt_s2;
               cand_vld <= 1'b1;
               stable   <= '0;
            end else if (stable != SETTLE_C) begin
               stable <= stable + 3'd1;
            end
         end
      end
   end

   assign accept = primed[1] && cand_vld && (cnt_s2 == cand) && (stable == SETTLE_C - 3'd1);
   assign delta  = cnt_s2 - count_sync;

   always_comb begin
      state_n = state;
      count_n = count_sync;
      dir_n   = dir_up;
      total_n = step_total;
      step_n  = 1'b0;
      wrap_n  = 1'b0;
      skip_n  = 1'b0;
      derr_n  = 1'b0;
      if (accept) begin
         count_n = cnt_s2;
         case (state)
            INIT: state_n = TRACK;
            TRACK: begin
               if (delta == 4'd1) begin
                  step_n = 1'b1;
                  dir_n  = 1'b1;
                  wrap_n = (count_sync == 4'd15);
                  derr_n = ud_s2;
               end else if (delta == 4'd15) begin
                  step_n = 1'b1;
                  dir_n  = 1'b0;
                  wrap_n = (count_sync == 4'd0);
                  derr_n = !ud_s2;
               end else if (delta != 4'd0) begin
                  skip_n = 1'b1;
               end
               if (step_n && step_total != 8'd255) total_n = step_total + 8'd1;
            end
            default: state_n = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state      <= INIT;
         count_sync <= '0;
         dir_up     <= 1'b0;
         step_total <= '0;
         step_pulse <= 1'b0;
         wrap_pulse <= 1'b0;
         skip_err   <= 1'b0;
         dir_err    <= 1'b0;
      end else begin
         state      <= state_n;
         count_sync <= count_n;
         dir_up     <= dir_n;
         step_total <= total_n;
         step_pulse <= step_n;
         wrap_pulse <= wrap_n;
         skip_err   <= skip_n;
         dir_err    <= derr_n;
      end
   end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: a sample-history reference model is compared against the DUT on every cycle.
// Directed scenarios with literal expectations come first, then randomized ripple-like stimulus.
module tb_ripple_count_monitor;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [3:0] cnt_in = 4'd0;
   logic       up_down = 1'b0;
   logic [3:0] count_sync;
   logic       step_pulse, dir_up, wrap_pulse, skip_err, dir_err;
   logic [7:0] step_total;

   int errors = 0;
   int checks = 0;

   ripple_count_monitor #(.SETTLE(SETTLE)) dut (
      .clk(clk), .clear(clear), .cnt_in(cnt_in), .up_down(up_down),
      .count_sync(count_sync), .step_pulse(step_pulse), .dir_up(dir_up),
      .wrap_pulse(wrap_pulse), .skip_err(skip_err), .dir_err(dir_err),
      .step_total(step_total)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: hist holds {up_down, cnt_in} sampled at each edge since
   // reset. A run of SETTLE+1 identical samples is accepted two edges after
   // its last sample; up_down is taken from the same delayed position.
   logic [4:0] hist[$];
   bit         m_track;
   int         m_count, m_dir, m_total, m_step, m_wrap, m_skip, m_derr;

   always @(posedge clk) begin
      int n, st, v, d, ud;
      bit ok;
      m_step = 0; m_wrap = 0; m_skip = 0; m_derr = 0;
      if (clear) begin
         hist.delete();
         m_track = 0; m_count = 0; m_dir = 0; m_total = 0;
      end else begin
         hist.push_back({up_down, cnt_in});
         n = hist.size();
         if (n >= 3 + SETTLE) begin
            st = n - 2 - SETTLE;
            v  = int'(hist[st-1][3:0]);
            ok = 1;
            for (int i = st - 1; i <= n - 3; i++)
               if (int'(hist[i][3:0]) != v) ok = 0;
            if (st > 1 && int'(hist[st-2][3:0]) == v) ok = 0;
            if (ok) begin
               ud = int'(hist[n-3][4]);
               if (m_track) begin
                  d = (v - m_count + 16) % 16;
                  if (d == 1 || d == 15) begin
                     m_step  = 1;
                     m_dir   = (d == 1) ? 1 : 0;
                     m_wrap  = (d == 1) ? int'(m_count == 15) : int'(m_count == 0);
                     m_derr  = int'(m_dir == ud);
                     m_total = (m_total < 255) ? m_total + 1 : 255;
                  end else if (d != 0) begin
                     m_skip = 1;
                  end
               end
               m_track = 1;
               m_count = v;
            end
         end
      end
   end

   always @(negedge clk) begin
      cmp("count_sync", int'(count_sync), m_count);
      cmp("step_pulse", int'(step_pulse), m_step);
      cmp("dir_up",     int'(dir_up),     m_dir);
      cmp("wrap_pulse", int'(wrap_pulse), m_wrap);
      cmp("skip_err",   int'(skip_err),   m_skip);
      cmp("dir_err",    int'(dir_err),    m_derr);
      cmp("step_total", int'(step_total), m_total);
   end

   task automatic wait_edges(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      logic [3:0] v;
      cnt_in = 4'd3;
      wait_edges(2);
      cmp("lit_reset_count", int'(count_sync), 0);
      cmp("lit_reset_total", int'(step_total), 0);
      clear = 1'b0;
      wait_edges(4);
      cmp("lit_init_not_yet", int'(count_sync), 0);
      wait_edges(1);
      cmp("lit_init_count", int'(count_sync), 3);
      cmp("lit_init_nopulse", int'(step_pulse | skip_err | wrap_pulse), 0);
      cmp("lit_init_total", int'(step_total), 0);
      wait_edges(3);

      cnt_in = 4'd4;
      wait_edges(5);
      cmp("lit_up_step", int'(step_pulse), 1);
      cmp("lit_up_dir", int'(dir_up), 1);
      cmp("lit_up_total", int'(step_total), 1);
      cmp("lit_up_derr", int'(dir_err), 0);
      wait_edges(1);
      cmp("lit_up_one_cycle", int'(step_pulse), 0);

      for (int i = 5; i <= 15; i++) begin
         cnt_in = 4'(i);
         wait_edges(4);
      end
      cnt_in = 4'd0;
      wait_edges(5);
      cmp("lit_wrap_up_step", int'(step_pulse), 1);
      cmp("lit_wrap_up_wrap", int'(wrap_pulse), 1);
      cmp("lit_wrap_up_total", int'(step_total), 13);
      up_down = 1'b1;
      wait_edges(3);
      cnt_in = 4'd15;
      wait_edges(5);
      cmp("lit_wrap_dn_step", int'(step_pulse), 1);
      cmp("lit_wrap_dn_wrap", int'(wrap_pulse), 1);
      cmp("lit_wrap_dn_dir", int'(dir_up), 0);
      cmp("lit_wrap_dn_derr", int'(dir_err), 0);

      for (int i = 14; i >= 7; i--) begin
         cnt_in = 4'(i);
         wait_edges(4);
      end
      up_down = 1'b0;
      wait_edges(3);
      cnt_in = 4'd6;
      wait_edges(1);
      cnt_in = 4'd8;
      wait_edges(4);
      cmp("lit_glitch_hold", int'(count_sync), 7);
      wait_edges(1);
      cmp("lit_glitch_step", int'(step_pulse), 1);
      cmp("lit_glitch_dir", int'(dir_up), 1);
      cmp("lit_glitch_count", int'(count_sync), 8);
      cmp("lit_glitch_total", int'(step_total), 23);
      cnt_in = 4'd12;
      wait_edges(5);
      cmp("lit_skip_err", int'(skip_err), 1);
      cmp("lit_skip_count", int'(count_sync), 12);
      cmp("lit_skip_total", int'(step_total), 23);
      cmp("lit_skip_nostep", int'(step_pulse), 0);

      cnt_in = 4'd5;
      up_down = 1'b1;
      wait_edges(5);
      cnt_in = 4'd6;
      wait_edges(5);
      cmp("lit_derr_step", int'(step_pulse), 1);
      cmp("lit_derr", int'(dir_err), 1);

      up_down = 1'b0;
      wait_edges(3);
      v = 4'd6;
      for (int i = 0; i < 300; i++) begin
         v = v + 4'd1;
         cnt_in = v;
         wait_edges(3);
      end
      wait_edges(5);
      cmp("lit_saturate", int'(step_total), 255);

      cnt_in = v + 4'd3;
      wait_edges(2);
      #1 clear = 1'b1;
      #1;
      cmp("lit_clr_count", int'(count_sync), 0);
      cmp("lit_clr_total", int'(step_total), 0);
      cmp("lit_clr_dir", int'(dir_up), 0);
      cmp("lit_clr_pulses", int'(step_pulse | wrap_pulse | skip_err | dir_err), 0);
      @(negedge clk);
      clear = 1'b0;
      wait_edges(4);
      cmp("lit_restart_wait", int'(count_sync), 0);
      wait_edges(1);
      cmp("lit_restart_count", int'(count_sync), int'(v + 4'd3));
      cmp("lit_restart_nopulse", int'(step_pulse | skip_err), 0);
      cmp("lit_restart_total", int'(step_total), 0);

      v = cnt_in;
      for (int it = 0; it < 700; it++) begin
         int r;
         r = $urandom_range(0, 39);
         if (r < 24) begin
            v = ($urandom_range(0, 1) == 1) ? v + 4'd1 : v - 4'd1;
            cnt_in = v;
            wait_edges($urandom_range(3, 6));
         end else if (r < 30) begin
            cnt_in = 4'($urandom_range(0, 15));
            wait_edges($urandom_range(1, SETTLE));
            if ($urandom_range(0, 1) == 1) v = v + 4'd1;
            cnt_in = v;
            wait_edges($urandom_range(1, 5));
         end else if (r < 34) begin
            v = 4'($urandom_range(0, 15));
            cnt_in = v;
            wait_edges($urandom_range(2, 5));
         end else if (r < 39) begin
            up_down = ~up_down;
            wait_edges($urandom_range(1, 3));
         end else begin
            #1 clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            wait_edges($urandom_range(1, 4));
         end
      end
      wait_edges(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 Parameter SETTLE, default 2, range 1..7: consecutive identical synchronized samples required before a value is accepted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 cnt_in  input  4  count from the asynchronous up/down ripple counter; asynchronous to clk and may glitch while rippling.
REQ-005 up_down  input  1  expected direction (0 = up, 1 = down); asynchronous, synchronized internally.
REQ-006 count_sync  output  4  last accepted counter value.
REQ-007 step_pulse  output  1  one-cycle pulse on each accepted +/-1 step.
REQ-008 dir_up  output  1  direction of the last accepted step (1 = up); holds between steps.
REQ-009 wrap_pulse  output  1  one-cycle pulse on an accepted 15->0 up-step or 0->15 down-step.
REQ-010 skip_err  output  1  one-cycle pulse when an accepted value differs from count_sync by neither +1 nor -1 (mod 16).
REQ-011 dir_err  output  1  one-cycle pulse when an accepted step direction disagrees with synchronized up_down.
REQ-012 step_total  output  8  number of accepted steps since reset; saturates at 255.

Function
REQ-013 cnt_in and up_down SHALL each pass through a two-flop synchronizer before use.
REQ-014 Filter: cand register plus stable counter; when synced cnt_in != cand, load cand and clear the stable counter; otherwise increment it, saturating at SETTLE.
REQ-015 A value SHALL be accepted on the edge at which the stable counter reaches SETTLE; each settled value is accepted once only.
REQ-016 Latency: a cnt_in change held stable SHALL be accepted and produce its pulses at clk edge 3+SETTLE after the first edge sampling it (edge 5 with default SETTLE).
REQ-017 Glitches shorter than SETTLE+1 synchronized cycles SHALL produce no acceptance and no pulse.
REQ-018 FSM states INIT and TRACK; reset enters INIT.
REQ-019 INIT: first accepted value loads count_sync, asserts no pulse, leaves step_total unchanged, moves to TRACK.
REQ-020 TRACK: delta = accepted - count_sync mod 16; delta 1 = up step, delta 15 = down step, delta 0 = no action, any other delta = skip_err.
REQ-021 Any accepted value SHALL load count_sync, including skips; a skip leaves dir_up and step_total unchanged.
REQ-022 An up or down step SHALL assert step_pulse, update dir_up, and increment step_total unless it is already 255.
REQ-023 wrap_pulse SHALL coincide with step_pulse only for up 15->0 or down 0->15.
REQ-024 dir_err SHALL coincide with step_pulse when (dir_up_new == 1) equals (synced up_down == 1).
REQ-025 All pulses SHALL last exactly one cycle; simultaneous step_pulse, wrap_pulse and dir_err are legal.

Reset
REQ-026 While clear is high: count_sync=0, step_total=0, dir_up=0, all pulses 0, synchronizers, cand and stable counter = 0, state INIT; asynchronous, independent of clk.
REQ-027 Deasserting clear mid-count SHALL restart in INIT; the first accepted value loads without a pulse.

Verification
REQ-028 Reset, cnt_in=3 held -> count_sync=3 at edge 5, no pulses, step_total=0.
REQ-029 TRACK at 3, up_down=0, cnt_in=4 -> step_pulse and dir_up=1 at edge 5, step_total=1, dir_err=0.
REQ-030 TRACK at 15, up_down=0, cnt_in=0 -> step_pulse and wrap_pulse together; at 0, up_down=1, cnt_in=15 -> step_pulse, wrap_pulse, dir_up=0.
REQ-031 TRACK at 7, cnt_in 7->6 (1-cycle glitch)->8 held -> no pulse from 6; 8 accepted with step_pulse, dir_up=1. TRACK at 8, cnt_in=12 -> skip_err, count_sync=12, step_total unchanged.
REQ-032 up_down=1 while cnt_in steps 5->6 -> step_pulse with dir_err=1. 300 up-steps -> step_total=255.
REQ-033 clear pulsed during a settle window -> all outputs 0 immediately; next settled value loads with no pulse.
